// File: rtl/icache_refill.sv
// icache_refill: I-cache miss fill engine.
// Watches the fetch lookup, fetches each missing 64-bit word from L2 one
// request at a time, then writes the whole fetch group into the cache on a
// single-cycle FILL pulse.
// Optional feature macro: ICACHE_REFILL_TIMEOUT_EN (L2 response timeout and
// the refill_timeout output).
module icache_refill #(
    parameter int ADDR_W      = 64,
    parameter int WORD_W      = 64,
`ifdef ICACHE_REFILL_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 255,
`endif
    parameter int LANES       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_valid,
    input  logic [ADDR_W-1:0]         address,
    input  logic [LANES-1:0]          cache_hit,
    input  logic                      flush,
    output logic                      refill_busy,
    output logic                      l2_req_valid,
    output logic [ADDR_W-1:0]         l2_req_addr,
    input  logic                      l2_req_ready,
    input  logic                      l2_rsp_valid,
    input  logic [WORD_W-1:0]         l2_rsp_data,
    output logic [LANES*ADDR_W-1:0]   data_in_adderss,
    output logic [LANES*WORD_W-1:0]   data_in_data,
    output logic [LANES-1:0]          data_in_start,
`ifdef ICACHE_REFILL_TIMEOUT_EN
    output logic                      refill_timeout,
`endif
    output logic [31:0]               refill_count
);

    localparam int LW = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, REQ, RESP, FILL, SETTLE, DRAIN} state_t;

    state_t                         state, state_nxt;
    logic [ADDR_W-1:0]              base_q;
    logic [LANES-1:0]               mask_q;
    logic [LW-1:0]                  lane_q;
    logic [LANES-1:0][WORD_W-1:0]   buf_q;
    logic [LANES-1:0][ADDR_W-1:0]   lane_addr;
    logic [LANES-1:0][WORD_W-1:0]   lane_data;
    logic [LW:0]                    first_pick, next_pick;
    logic                           accept, hs, rsp_take, waiting, tmo;

    // Returns {found, index} of the lowest set mask bit strictly above 'above'.
    function automatic logic [LW:0] pick_lane(input logic [LANES-1:0] mask, input int above);
        pick_lane = '0;
        for (int i = LANES-1; i >= 0; i--)
            if (mask[i] && i > above) pick_lane = {1'b1, LW'(i)};
    endfunction

    assign accept     = (state == IDLE) && fetch_valid && (cache_hit != '1) && !flush;
    assign hs         = (state == REQ) && l2_req_ready;
    assign rsp_take   = (state == RESP) && l2_rsp_valid && !flush && !tmo;
    assign waiting    = (state == RESP) || (state == DRAIN);
    assign first_pick = pick_lane(~cache_hit, -1);
    assign next_pick  = pick_lane(mask_q, int'(lane_q));

    // Per-lane fill view: every lane gets its address, only missed lanes carry data.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        assign lane_addr[n] = base_q + ADDR_W'(8*n);
        assign lane_data[n] = mask_q[n] ? buf_q[n] : '0;
    end

`ifdef ICACHE_REFILL_TIMEOUT_EN
    logic [7:0] tcnt;

    // Wait counter: restarts on any state change, counts cycles spent waiting for L2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 tcnt <= '0;
        else if (state_nxt != state) tcnt <= '0;
        else if (waiting)           tcnt <= tcnt + 8'd1;
    end

    assign tmo            = waiting && !l2_rsp_valid && (tcnt == 8'(TIMEOUT_CYC-1));
    assign refill_timeout = tmo;
`else
    assign tmo = 1'b0;
`endif

    // State register plus miss context, response buffers and the refill counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            base_q       <= '0;
            mask_q       <= '0;
            lane_q       <= '0;
            buf_q        <= '0;
            refill_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base_q <= address;
                mask_q <= ~cache_hit;
                lane_q <= first_pick[LW-1:0];
            end
            if (rsp_take) begin
                buf_q[lane_q] <= l2_rsp_data;
                lane_q        <= next_pick[LW-1:0];
            end
            if (state == FILL && refill_count != '1)
                refill_count <= refill_count + 32'd1;
        end
    end

    // Next-state and output decode; a FILL already in progress still pulses on flush.
    always_comb begin
        state_nxt       = state;
        refill_busy     = (state != IDLE);
        l2_req_valid    = 1'b0;
        l2_req_addr     = '0;
        data_in_start   = '0;
        data_in_adderss = '0;
        data_in_data    = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                l2_req_valid = 1'b1;
                l2_req_addr  = base_q + ADDR_W'({lane_q, 3'b000});
                if (flush)   state_nxt = hs ? DRAIN : IDLE;
                else if (hs) state_nxt = RESP;
            end
            RESP: begin
                if (tmo)               state_nxt = IDLE;
                else if (flush)        state_nxt = l2_rsp_valid ? IDLE : DRAIN;
                else if (l2_rsp_valid) state_nxt = next_pick[LW] ? REQ : FILL;
            end
            FILL: begin
                data_in_start   = mask_q;
                data_in_adderss = lane_addr;
                data_in_data    = lane_data;
                state_nxt       = flush ? IDLE : SETTLE;
            end
            SETTLE: state_nxt = IDLE;
            DRAIN: begin
                if (tmo || l2_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: randomized self-checking bench for icache_refill.
// A simple L2 responder drives the handshake; expected requests and fill
// contents come from a fetch-group level model (missed lanes in ascending
// order, responses consumed in that order).
module tb_icache_refill;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_valid;
    logic [63:0]  address;
    logic [3:0]   cache_hit;
    logic         flush;
    logic         refill_busy;
    logic         l2_req_valid;
    logic [63:0]  l2_req_addr;
    logic         l2_req_ready;
    logic         l2_rsp_valid;
    logic [63:0]  l2_rsp_data;
    logic [255:0] data_in_adderss;
    logic [255:0] data_in_data;
    logic [3:0]   data_in_start;
    logic [31:0]  refill_count;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    logic         refill_timeout;
`endif

    int checks = 0;
    int errors = 0;

    icache_refill dut (
        .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .address(address),
        .cache_hit(cache_hit), .flush(flush), .refill_busy(refill_busy),
        .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_data(l2_rsp_data),
        .data_in_adderss(data_in_adderss), .data_in_data(data_in_data),
        .data_in_start(data_in_start),
`ifdef ICACHE_REFILL_TIMEOUT_EN
        .refill_timeout(refill_timeout),
`endif
        .refill_count(refill_count)
    );

    always #5 clk = ~clk;

    // L2 word returned for the k-th response of a refill
    logic [63:0]  words [4];
    // observed by the driver
    logic [63:0]  obs_q [$];
    int           obs_fills;
    int           obs_unstable;
    bit           obs_tmo;
    logic [3:0]   obs_start;
    logic [255:0] obs_addr, obs_data;
    // reference model
    logic [63:0]  exp_q [$];
    logic [3:0]   exp_start;
    logic [255:0] exp_addr, exp_data;

    // Fetch-group model: missed lanes are fetched lowest first, all lanes get base+8n.
    function automatic void model(input logic [63:0] b, input logic [3:0] hit);
        int k = 0;
        exp_q.delete();
        exp_start = ~hit;
        exp_addr  = '0;
        exp_data  = '0;
        for (int n = 0; n < 4; n++) begin
            exp_addr[64*n +: 64] = b + 64'(8*n);
            if (!hit[n]) begin
                exp_q.push_back(b + 64'(8*n));
                exp_data[64*n +: 64] = words[k];
                k++;
            end
        end
    endfunction

    // Presents one lookup and plays L2 until the engine returns to idle.
    task automatic do_refill(input logic [63:0] b, input logic [3:0] hit, input int bp, input int rdly);
        int          wait_c = 0, rsp_wait = 0, rsp_idx = 0;
        bit          pending = 0, done = 0;
        logic [63:0] cur = '0;
        obs_q.delete();
        obs_fills = 0; obs_unstable = 0; obs_tmo = 1; obs_start = '0; obs_addr = '0; obs_data = '0;
        @(negedge clk);
        fetch_valid = 1; address = b; cache_hit = hit;
        @(negedge clk);
        fetch_valid = 1; address = {$urandom, $urandom}; cache_hit = 4'($urandom);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            l2_req_ready = 0;
            l2_rsp_valid = 0;
            if (data_in_start != 0) begin
                obs_fills++;
                obs_start = data_in_start; obs_addr = data_in_adderss; obs_data = data_in_data;
            end
            if (!refill_busy) begin
                done = 1; obs_tmo = 0;
            end else if (pending) begin
                if (rsp_wait == 0) begin
                    l2_rsp_valid = 1; l2_rsp_data = words[rsp_idx]; rsp_idx++; pending = 0;
                end else rsp_wait--;
            end else if (l2_req_valid) begin
                if (wait_c == 0) cur = l2_req_addr;
                else if (l2_req_addr !== cur) obs_unstable++;
                if (wait_c >= bp) begin
                    l2_req_ready = 1; obs_q.push_back(l2_req_addr);
                    pending = 1; rsp_wait = rdly; wait_c = 0;
                end else wait_c++;
            end
            if (!done) @(negedge clk);
        end
        fetch_valid = 0; l2_req_ready = 0; l2_rsp_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0; fetch_valid = 0; address = '0; cache_hit = '0; flush = 0;
        l2_req_ready = 0; l2_rsp_valid = 0; l2_rsp_data = '0;
        #1;
        checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", refill_busy); end
        checks++; if (l2_req_valid !== 1'b0 || l2_req_addr !== 64'h0) begin errors++; $display("FAIL reset_req got %b/%h want 0/0", l2_req_valid, l2_req_addr); end
        checks++; if (data_in_start !== 4'h0 || data_in_adderss !== '0 || data_in_data !== '0) begin errors++; $display("FAIL reset_fill got %h want 0", data_in_start); end
        checks++; if (refill_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", refill_count); end
        @(negedge clk); reset = 1;
    endtask

    task automatic test_single_lane();
        words[0] = 64'hAAAA;
        do_refill(64'h1000, 4'b1101, 0, 0);
        checks++; if (obs_tmo) begin errors++; $display("FAIL single_timeout got stuck want idle"); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== 64'h1008) begin errors++; $display("FAIL single_req got %0d reqs first %h want 1 at 1008", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 64'h0); end
        checks++; if (obs_fills != 1 || obs_start !== 4'b0010) begin errors++; $display("FAIL single_start got %0d pulses %b want 1 pulse 0010", obs_fills, obs_start); end
        checks++; if (obs_data !== {64'h0, 64'h0, 64'hAAAA, 64'h0}) begin errors++; $display("FAIL single_data got %h want lane1 AAAA", obs_data); end
        checks++; if (obs_addr !== {64'h1018, 64'h1010, 64'h1008, 64'h1000}) begin errors++; $display("FAIL single_addr got %h want 1000/1008/1010/1018", obs_addr); end
        checks++; if (refill_count !== 32'd1) begin errors++; $display("FAIL single_count got %0d want 1", refill_count); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) words[i] = {$urandom, $urandom};
        do_refill(64'h1000, 4'b0000, 3, 1);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL bp_nreq got %0d want 4", obs_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (obs_q[i] !== 64'h1000 + 64'(8*i)) begin errors++; $display("FAIL bp_req%0d got %h want %h", i, obs_q[i], 64'h1000 + 64'(8*i)); end
        end
        checks++; if (obs_unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", obs_unstable); end
        checks++; if (obs_fills != 1 || obs_start !== 4'hF) begin errors++; $display("FAIL bp_start got %0d pulses %h want 1 pulse F", obs_fills, obs_start); end
        checks++; if (obs_data !== {words[3], words[2], words[1], words[0]}) begin errors++; $display("FAIL bp_data got %h", obs_data); end
        checks++; if (refill_count !== 32'd2) begin errors++; $display("FAIL bp_count got %0d want 2", refill_count); end
    endtask

    task automatic test_hit();
        int bad = 0;
        @(negedge clk);
        fetch_valid = 1; address = 64'h4000; cache_hit = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (refill_busy !== 1'b0 || l2_req_valid !== 1'b0) bad++;
        end
        fetch_valid = 0;
        checks++; if (bad != 0) begin errors++; $display("FAIL hit_idle got %0d busy/req cycles want 0", bad); end
        checks++; if (refill_count !== 32'd2) begin errors++; $display("FAIL hit_count got %0d want 2", refill_count); end
    endtask

    task automatic test_flush_resp();
        int starts = 0;
        @(negedge clk); fetch_valid = 1; address = 64'h3000; cache_hit = 4'h0;
        @(negedge clk); fetch_valid = 0; l2_req_ready = 1;
        checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 64'h3000) begin errors++; $display("FAIL flush_req0 got %b/%h want 1/3000", l2_req_valid, l2_req_addr); end
        @(negedge clk); l2_req_ready = 0; l2_rsp_valid = 1; l2_rsp_data = 64'h1111;
        @(negedge clk); l2_rsp_valid = 0; l2_req_ready = 1;
        checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 64'h3008) begin errors++; $display("FAIL flush_req1 got %b/%h want 1/3008", l2_req_valid, l2_req_addr); end
        @(negedge clk); l2_req_ready = 0; flush = 1;
        @(negedge clk); flush = 0;
        for (int i = 0; i < 3; i++) begin
            if (data_in_start != 0) starts++;
            checks++; if (refill_busy !== 1'b1 || l2_req_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got busy %b req %b want 1/0", refill_busy, l2_req_valid); end
            @(negedge clk);
        end
        l2_rsp_valid = 1; l2_rsp_data = 64'h2222;
        @(negedge clk); l2_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if (data_in_start != 0) starts++;
            @(negedge clk);
        end
        checks++; if (refill_busy !== 1'b0 || l2_req_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got busy %b req %b want 0/0", refill_busy, l2_req_valid); end
        checks++; if (starts != 0) begin errors++; $display("FAIL flush_nofill got %0d pulses want 0", starts); end
        checks++; if (refill_count !== 32'd2) begin errors++; $display("FAIL flush_count got %0d want 2", refill_count); end
    endtask

    task automatic test_wrap();
        words[0] = 64'h5A5A; words[1] = 64'hA5A5;
        do_refill(64'hFFFF_FFFF_FFFF_FFF0, 4'b0011, 1, 0);
        checks++; if (obs_q.size() != 2 || obs_q[0] !== 64'h0 || obs_q[1] !== 64'h8) begin errors++; $display("FAIL wrap_req got %0d reqs want 0 and 8", obs_q.size()); end
        checks++; if (obs_addr !== {64'h8, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF0}) begin errors++; $display("FAIL wrap_addr got %h", obs_addr); end
        checks++; if (obs_start !== 4'b1100 || obs_data !== {64'hA5A5, 64'h5A5A, 128'h0}) begin errors++; $display("FAIL wrap_fill got %b %h", obs_start, obs_data); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); fetch_valid = 1; address = 64'h7000; cache_hit = 4'h0;
        @(negedge clk); fetch_valid = 0;
        checks++; if (l2_req_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %b want 1", l2_req_valid); end
        #2 reset = 0;
        #1;
        checks++; if (refill_busy !== 1'b0 || l2_req_valid !== 1'b0 || l2_req_addr !== 64'h0 || refill_count !== 32'h0) begin
            errors++; $display("FAIL areset_out got busy %b req %b addr %h cnt %0d want all 0", refill_busy, l2_req_valid, l2_req_addr, refill_count); end
        @(negedge clk); reset = 1;
        words[0] = 64'hBEEF;
        do_refill(64'h2000, 4'b1110, 0, 1);
        checks++; if (obs_q.size() != 1 || obs_q[0] !== 64'h2000 || obs_data !== {192'h0, 64'hBEEF}) begin errors++; $display("FAIL areset_after got %0d reqs data %h", obs_q.size(), obs_data); end
        checks++; if (refill_count !== 32'd1) begin errors++; $display("FAIL areset_count got %0d want 1", refill_count); end
    endtask

    task automatic test_random();
        logic [63:0] b;
        logic [3:0]  hit;
        logic [31:0] cnt;
        int          bad;
        for (int it = 0; it < 25; it++) begin
            b   = {$urandom, $urandom} & ~64'h7;
            hit = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) words[i] = {$urandom, $urandom};
            cnt = refill_count;
            model(b, hit);
            do_refill(b, hit, $urandom_range(0, 3), $urandom_range(0, 3));
            bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
            for (int i = 0; i < obs_q.size() && bad == 0; i++) if (obs_q[i] !== exp_q[i]) bad = 1;
            checks++; if (obs_tmo || bad != 0 || obs_unstable != 0) begin errors++; $display("FAIL rand%0d_req got %0d reqs (stuck %0d, unstable %0d) want %0d", it, obs_q.size(), obs_tmo, obs_unstable, exp_q.size()); end
            checks++; if (obs_fills != ((hit != 4'hF) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_pulses got %0d", it, obs_fills); end
            if (hit != 4'hF) begin
                checks++; if (obs_start !== exp_start || obs_addr !== exp_addr || obs_data !== exp_data) begin errors++; $display("FAIL rand%0d_fill got %b want %b", it, obs_start, exp_start); end
            end
            checks++; if (refill_count !== cnt + ((hit != 4'hF) ? 32'd1 : 32'd0)) begin errors++; $display("FAIL rand%0d_count got %0d", it, refill_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_backpressure();
        test_hit();
        test_flush_resp();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
